// File: rtl/sensor_capture_ctrl.sv
// Frame-capture sequencer: arms on request, crops whole sensor frames and gates them to the writer.
// Optional stall watchdog is compiled in when SENSOR_CAPTURE_TIMEOUT_EN is defined.
module sensor_capture_ctrl #(
  parameter int unsigned          PIX_W       = 12,
  parameter int unsigned          CNT_W       = 16,
  parameter int unsigned          TIMEOUT_W   = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic             sensor_pclk,
  input  logic             cam_reset,
  input  logic             sensor_startframe,
  input  logic             sensor_startline,
  input  logic             sensor_endline,
  input  logic             sensor_endframe,
  input  logic             sensor_datavalid,
  input  logic [PIX_W-1:0] cfg_x_start,
  input  logic [PIX_W-1:0] cfg_x_end,
  input  logic [PIX_W-1:0] cfg_y_start,
  input  logic [PIX_W-1:0] cfg_y_end,
  input  logic             cfg_continuous,
  input  logic             cap_arm,
  input  logic             cap_abort,
  input  logic             wr_ready,
  output logic             wr_valid,
  output logic             wr_sof,
  output logic             wr_eol,
  output logic             wr_eof,
  output logic             cap_busy,
  output logic             frame_done,
  output logic             frame_dropped,
  output logic [CNT_W-1:0] frame_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  state_t           state;
  logic [PIX_W-1:0] pix_x, line_y;
  logic [PIX_W-1:0] cur_x, cur_y;
  logic [PIX_W-1:0] xs, xe, ys, ye;
  logic             first_pend;
  logic             in_win;
  logic             hit;
  logic             wd_fire;

  function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
    return (v == PIX_MAX) ? v : v + 1'b1;
  endfunction

  // Coordinate of the pixel on this cycle; a same-cycle line/frame start restarts the count.
  always_comb begin
    cur_x  = sensor_startline  ? '0 : pix_x;
    cur_y  = sensor_startframe ? '0 : line_y;
    in_win = (cur_x >= xs) && (cur_x <= xe) && (cur_y >= ys) && (cur_y <= ye);
    hit    = sensor_datavalid && (state == CAPTURE) && in_win && !cap_abort;
  end

`ifdef SENSOR_CAPTURE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_activity;

  assign wd_activity = sensor_datavalid || sensor_startline;
  assign wd_fire     = (state == CAPTURE) && !wd_activity &&
                       (wd_cnt == TIMEOUT_CYC - 1'b1);

  always_ff @(posedge sensor_pclk or posedge cam_reset) begin
    if (cam_reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= wd_fire && !cap_abort;
      if (state != CAPTURE || wd_activity)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge sensor_pclk or posedge cam_reset) begin
    if (cam_reset) begin
      state         <= IDLE;
      pix_x         <= '0;
      line_y        <= '0;
      xs            <= '0;
      xe            <= '0;
      ys            <= '0;
      ye            <= '0;
      first_pend    <= 1'b0;
      wr_valid      <= 1'b0;
      wr_sof        <= 1'b0;
      wr_eol        <= 1'b0;
      wr_eof        <= 1'b0;
      cap_busy      <= 1'b0;
      frame_done    <= 1'b0;
      frame_dropped <= 1'b0;
      frame_count   <= '0;
    end else begin
      pix_x         <= sensor_datavalid ? sat_inc(cur_x) : cur_x;
      line_y        <= sensor_endline   ? sat_inc(cur_y) : cur_y;
      wr_valid      <= hit;
      wr_sof        <= hit && first_pend;
      wr_eol        <= hit && (cur_x == xe);
      wr_eof        <= hit && (cur_x == xe) && (cur_y == ye);
      frame_done    <= 1'b0;
      frame_dropped <= 1'b0;
      if (hit)
        first_pend <= 1'b0;

      case (state)
        IDLE: begin
          if (cap_arm && !cap_abort) begin
            state    <= ARMED;
            cap_busy <= 1'b1;
          end
        end
        ARMED: begin
          if (cap_abort) begin
            state    <= IDLE;
            cap_busy <= 1'b0;
          end else if (sensor_startframe) begin
            if (wr_ready) begin
              state      <= CAPTURE;
              xs         <= cfg_x_start;
              xe         <= cfg_x_end;
              ys         <= cfg_y_start;
              ye         <= cfg_y_end;
              first_pend <= 1'b1;
            end else begin
              frame_dropped <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          // A startframe coinciding with endframe is deliberately not captured.
          if (cap_abort || wd_fire) begin
            state         <= IDLE;
            cap_busy      <= 1'b0;
            frame_dropped <= 1'b1;
          end else if (sensor_endframe) begin
            state       <= DONE;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
          end
        end
        DONE: begin
          if (cap_abort || !cfg_continuous) begin
            state    <= IDLE;
            cap_busy <= 1'b0;
          end else begin
            state <= ARMED;
          end
        end
        default: begin
          state    <= IDLE;
          cap_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_capture_ctrl.sv
// Randomized bench for sensor_capture_ctrl; expected pixel streams come from a frame-level crop model.
module tb_sensor_capture_ctrl;

  logic        sensor_pclk = 1'b0;
  logic        cam_reset = 1'b1;
  logic        sensor_startframe = 1'b0, sensor_startline = 1'b0;
  logic        sensor_endline = 1'b0, sensor_endframe = 1'b0, sensor_datavalid = 1'b0;
  logic [11:0] cfg_x_start = '0, cfg_x_end = '0, cfg_y_start = '0, cfg_y_end = '0;
  logic        cfg_continuous = 1'b0, cap_arm = 1'b0, cap_abort = 1'b0, wr_ready = 1'b1;
  logic        wr_valid, wr_sof, wr_eol, wr_eof, cap_busy, frame_done, frame_dropped, timeout_err;
  logic [15:0] frame_count;

  sensor_capture_ctrl #(.PIX_W(12), .CNT_W(16), .TIMEOUT_W(24), .TIMEOUT_CYC(24'd100)) dut (
    .sensor_pclk(sensor_pclk), .cam_reset(cam_reset),
    .sensor_startframe(sensor_startframe), .sensor_startline(sensor_startline),
    .sensor_endline(sensor_endline), .sensor_endframe(sensor_endframe),
    .sensor_datavalid(sensor_datavalid),
    .cfg_x_start(cfg_x_start), .cfg_x_end(cfg_x_end),
    .cfg_y_start(cfg_y_start), .cfg_y_end(cfg_y_end),
    .cfg_continuous(cfg_continuous), .cap_arm(cap_arm), .cap_abort(cap_abort),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_eol(wr_eol),
    .wr_eof(wr_eof), .cap_busy(cap_busy), .frame_done(frame_done),
    .frame_dropped(frame_dropped), .frame_count(frame_count), .timeout_err(timeout_err)
  );

  always #5 sensor_pclk = ~sensor_pclk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  // Output monitor: records {sof,eol,eof} of every written pixel and counts status pulses.
  logic [2:0] mon_q [0:4095];
  int mon_n = 0, done_n = 0, drop_n = 0, tmo_n = 0, stray_n = 0;
  always @(negedge sensor_pclk) begin
    if (wr_valid) begin
      mon_q[mon_n[11:0]] <= {wr_sof, wr_eol, wr_eof};
      mon_n <= mon_n + 1;
    end
    if (!wr_valid && (wr_sof || wr_eol || wr_eof)) stray_n <= stray_n + 1;
    if (frame_done)    done_n <= done_n + 1;
    if (frame_dropped) drop_n <= drop_n + 1;
    if (timeout_err)   tmo_n  <= tmo_n + 1;
  end

  // Reference: the expected pixel flag stream of one captured frame.
  logic [2:0] exp_q [0:4095];
  int exp_n = 0;
  task automatic model_frame(input int w, input int h, input int xs, input int xe,
                             input int ys, input int ye);
    bit first = 1'b1;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (x >= xs && x <= xe && y >= ys && y <= ye) begin
          exp_q[exp_n] = {first, x == xe, (x == xe) && (y == ye)};
          first = 1'b0;
          exp_n++;
        end
  endtask

  task automatic cyc();
    @(posedge sensor_pclk);
    #1;
  endtask

  task automatic set_win(input int xs, input int xe, input int ys, input int ye);
    cfg_x_start = 12'(xs); cfg_x_end = 12'(xe);
    cfg_y_start = 12'(ys); cfg_y_end = 12'(ye);
  endtask

  task automatic arm();
    cap_arm = 1'b1; cyc(); cap_arm = 1'b0;
  endtask

  task automatic abort();
    cap_abort = 1'b1; cyc(); cap_abort = 1'b0;
  endtask

  // Drives one sensor frame of w x h pixels with random pixel gaps; optionally
  // reprograms the crop window at the start of line chg_y.
  task automatic drive_frame(input int w, input int h, input int chg_y,
                             input int nxs, input int nxe, input int nys, input int nye);
    sensor_startframe = 1'b1; cyc(); sensor_startframe = 1'b0; cyc();
    for (int y = 0; y < h; y++) begin
      if (y == chg_y) set_win(nxs, nxe, nys, nye);
      sensor_startline = 1'b1; cyc(); sensor_startline = 1'b0;
      for (int x = 0; x < w; x++) begin
        repeat ($urandom_range(0, 1)) cyc();
        sensor_datavalid = 1'b1; cyc(); sensor_datavalid = 1'b0;
      end
      sensor_endline = 1'b1; cyc(); sensor_endline = 1'b0; cyc();
    end
    sensor_endframe = 1'b1; cyc(); sensor_endframe = 1'b0; cyc(); cyc();
  endtask

  task automatic test_reset();
    cam_reset = 1'b1;
    repeat (3) cyc();
    n_checks++;
    if ({wr_valid, wr_sof, wr_eol, wr_eof} !== 4'b0)
      $display("FAIL reset_wr: got %b expected 0000", {wr_valid, wr_sof, wr_eol, wr_eof});
    else n_pass++;
    n_checks++;
    if ({cap_busy, frame_done, frame_dropped, timeout_err} !== 4'b0)
      $display("FAIL reset_status: got %b expected 0000", {cap_busy, frame_done, frame_dropped, timeout_err});
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", frame_count);
    else n_pass++;
    cam_reset = 1'b0;
    repeat (2) cyc();
    n_checks++;
    if (cap_busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b expected 0", cap_busy);
    else n_pass++;
  endtask

  task automatic test_single_shot();
    int m0 = mon_n, d0 = done_n;
    exp_n = 0;
    cfg_continuous = 1'b0;
    set_win(2, 5, 1, 2);
    arm();
    n_checks++;
    if (cap_busy !== 1'b1) $display("FAIL ss_armed_busy: got %b expected 1", cap_busy);
    else n_pass++;
    drive_frame(8, 4, -1, 0, 0, 0, 0);
    model_frame(8, 4, 2, 5, 1, 2);
    exp_count++;
    n_checks++;
    if (mon_n - m0 !== exp_n) $display("FAIL ss_pixels: got %0d expected %0d", mon_n - m0, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n && m0 + i < mon_n; i++) begin
      n_checks++;
      if (mon_q[m0 + i] !== exp_q[i])
        $display("FAIL ss_flags[%0d]: got %b expected %b", i, mon_q[m0 + i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_n - d0 !== 1) $display("FAIL ss_done: got %0d expected 1", done_n - d0);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'(exp_count)) $display("FAIL ss_count: got %0d expected %0d", frame_count, exp_count);
    else n_pass++;
    n_checks++;
    if (cap_busy !== 1'b0) $display("FAIL ss_idle: busy=%b expected 0", cap_busy);
    else n_pass++;
  endtask

  task automatic test_continuous();
    int m0 = mon_n, d0 = done_n, p0 = drop_n;
    exp_n = 0;
    cfg_continuous = 1'b1;
    set_win(1, 3, 0, 1);
    arm();
    wr_ready = 1'b1; drive_frame(5, 3, -1, 0, 0, 0, 0); model_frame(5, 3, 1, 3, 0, 1);
    wr_ready = 1'b0; drive_frame(5, 3, -1, 0, 0, 0, 0);
    wr_ready = 1'b1; drive_frame(5, 3, -1, 0, 0, 0, 0); model_frame(5, 3, 1, 3, 0, 1);
    exp_count += 2;
    n_checks++;
    if (drop_n - p0 !== 1) $display("FAIL cont_dropped: got %0d expected 1", drop_n - p0);
    else n_pass++;
    n_checks++;
    if (done_n - d0 !== 2) $display("FAIL cont_done: got %0d expected 2", done_n - d0);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'(exp_count)) $display("FAIL cont_count: got %0d expected %0d", frame_count, exp_count);
    else n_pass++;
    n_checks++;
    if (cap_busy !== 1'b1) $display("FAIL cont_still_armed: busy=%b expected 1", cap_busy);
    else n_pass++;
    n_checks++;
    if (mon_n - m0 !== exp_n) $display("FAIL cont_pixels: got %0d expected %0d", mon_n - m0, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n && m0 + i < mon_n; i++) begin
      n_checks++;
      if (mon_q[m0 + i] !== exp_q[i])
        $display("FAIL cont_flags[%0d]: got %b expected %b", i, mon_q[m0 + i], exp_q[i]);
      else n_pass++;
    end
    cfg_continuous = 1'b0;
    abort();
    n_checks++;
    if (cap_busy !== 1'b0) $display("FAIL cont_abort_idle: busy=%b expected 0", cap_busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    int d0 = done_n, p0;
    set_win(0, 7, 0, 3);
    arm();
    sensor_startframe = 1'b1; cyc(); sensor_startframe = 1'b0;
    sensor_startline = 1'b1; cyc(); sensor_startline = 1'b0;
    repeat (3) begin sensor_datavalid = 1'b1; cyc(); end
    p0 = drop_n;
    cap_abort = 1'b1; cyc(); cap_abort = 1'b0; sensor_datavalid = 1'b0;
    n_checks++;
    if (wr_valid !== 1'b0) $display("FAIL abort_gate: wr_valid=%b expected 0", wr_valid);
    else n_pass++;
    n_checks++;
    if (frame_dropped !== 1'b1) $display("FAIL abort_dropped: got %b expected 1", frame_dropped);
    else n_pass++;
    n_checks++;
    if (cap_busy !== 1'b0) $display("FAIL abort_idle: busy=%b expected 0", cap_busy);
    else n_pass++;
    sensor_endline = 1'b1; cyc(); sensor_endline = 1'b0;
    sensor_endframe = 1'b1; cyc(); sensor_endframe = 1'b0; cyc(); cyc();
    n_checks++;
    if (done_n - d0 !== 0) $display("FAIL abort_no_done: got %0d expected 0", done_n - d0);
    else n_pass++;
    n_checks++;
    if (drop_n - p0 !== 1) $display("FAIL abort_drop_once: got %0d expected 1", drop_n - p0);
    else n_pass++;
    cap_arm = 1'b1; cap_abort = 1'b1; cyc(); cap_arm = 1'b0; cap_abort = 1'b0; cyc();
    n_checks++;
    if (cap_busy !== 1'b0) $display("FAIL abort_beats_arm: busy=%b expected 0", cap_busy);
    else n_pass++;
  endtask

  task automatic test_window_edges();
    int m0 = mon_n, d0 = done_n;
    exp_n = 0;
    set_win(6, 3, 0, 3);
    arm(); drive_frame(8, 4, -1, 0, 0, 0, 0); exp_count++;
    n_checks++;
    if (mon_n - m0 !== 0) $display("FAIL inverted_pixels: got %0d expected 0", mon_n - m0);
    else n_pass++;
    n_checks++;
    if (done_n - d0 !== 1) $display("FAIL inverted_done: got %0d expected 1", done_n - d0);
    else n_pass++;
    m0 = mon_n;
    set_win(2, 30, 1, 20);
    arm(); drive_frame(6, 3, -1, 0, 0, 0, 0); exp_count++;
    model_frame(6, 3, 2, 30, 1, 20);
    n_checks++;
    if (mon_n - m0 !== exp_n) $display("FAIL oversize_pixels: got %0d expected %0d", mon_n - m0, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n && m0 + i < mon_n; i++) begin
      n_checks++;
      if (mon_q[m0 + i] !== exp_q[i])
        $display("FAIL oversize_flags[%0d]: got %b expected %b", i, mon_q[m0 + i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_n - d0 !== 2) $display("FAIL oversize_done: got %0d expected 2", done_n - d0);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'(exp_count)) $display("FAIL edges_count: got %0d expected %0d", frame_count, exp_count);
    else n_pass++;
  endtask

  task automatic test_cfg_midframe();
    int m0 = mon_n;
    exp_n = 0;
    set_win(1, 4, 0, 2);
    arm(); drive_frame(6, 4, 1, 3, 5, 2, 3); model_frame(6, 4, 1, 4, 0, 2);
    arm(); drive_frame(6, 4, -1, 0, 0, 0, 0); model_frame(6, 4, 3, 5, 2, 3);
    exp_count += 2;
    n_checks++;
    if (mon_n - m0 !== exp_n) $display("FAIL midcfg_pixels: got %0d expected %0d", mon_n - m0, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n && m0 + i < mon_n; i++) begin
      n_checks++;
      if (mon_q[m0 + i] !== exp_q[i])
        $display("FAIL midcfg_flags[%0d]: got %b expected %b", i, mon_q[m0 + i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random_frames();
    int m0 = mon_n, d0 = done_n;
    exp_n = 0;
    for (int k = 0; k < 5; k++) begin
      int w = $urandom_range(3, 10), h = $urandom_range(2, 5);
      int xs = $urandom_range(0, w + 1), xe = $urandom_range(0, w + 1);
      int ys = $urandom_range(0, h + 1), ye = $urandom_range(0, h + 1);
      set_win(xs, xe, ys, ye);
      arm(); drive_frame(w, h, -1, 0, 0, 0, 0);
      model_frame(w, h, xs, xe, ys, ye);
      exp_count++;
    end
    n_checks++;
    if (mon_n - m0 !== exp_n) $display("FAIL rand_pixels: got %0d expected %0d", mon_n - m0, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n && m0 + i < mon_n; i++) begin
      n_checks++;
      if (mon_q[m0 + i] !== exp_q[i])
        $display("FAIL rand_flags[%0d]: got %b expected %b", i, mon_q[m0 + i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_n - d0 !== 5) $display("FAIL rand_done: got %0d expected 5", done_n - d0);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'(exp_count)) $display("FAIL rand_count: got %0d expected %0d", frame_count, exp_count);
    else n_pass++;
    n_checks++;
    if (stray_n !== 0) $display("FAIL stray_flags: got %0d expected 0", stray_n);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t0 = tmo_n, p0 = drop_n, n = 0;
    set_win(0, 7, 0, 3);
    arm();
    sensor_startframe = 1'b1; cyc(); sensor_startframe = 1'b0;
`ifdef SENSOR_CAPTURE_TIMEOUT_EN
    while (timeout_err !== 1'b1 && n < 200) begin cyc(); n++; end
    n_checks++;
    if (n !== 100) $display("FAIL timeout_latency: got %0d cycles expected 100", n);
    else n_pass++;
    n_checks++;
    if (frame_dropped !== 1'b1) $display("FAIL timeout_dropped: got %b expected 1", frame_dropped);
    else n_pass++;
    n_checks++;
    if (cap_busy !== 1'b0) $display("FAIL timeout_idle: busy=%b expected 0", cap_busy);
    else n_pass++;
    cyc();
    n_checks++;
    if (tmo_n - t0 !== 1 || drop_n - p0 !== 1)
      $display("FAIL timeout_pulses: tmo=%0d drop=%0d expected 1 1", tmo_n - t0, drop_n - p0);
    else n_pass++;
`else
    repeat (150) begin cyc(); n++; end
    n_checks++;
    if (tmo_n - t0 !== 0) $display("FAIL no_watchdog_tmo: got %0d expected 0 after %0d cycles", tmo_n - t0, n);
    else n_pass++;
    n_checks++;
    if (cap_busy !== 1'b1 || drop_n - p0 !== 0)
      $display("FAIL no_watchdog_state: busy=%b drops=%0d expected 1 0", cap_busy, drop_n - p0);
    else n_pass++;
    abort();
`endif
  endtask

  task automatic test_reset_midframe();
    set_win(0, 7, 0, 3);
    arm();
    sensor_startframe = 1'b1; cyc(); sensor_startframe = 1'b0;
    sensor_startline = 1'b1; cyc(); sensor_startline = 1'b0;
    sensor_datavalid = 1'b1; cyc();
    n_checks++;
    if (wr_valid !== 1'b1) $display("FAIL pre_reset_pixel: wr_valid=%b expected 1", wr_valid);
    else n_pass++;
    #2 cam_reset = 1'b1;
    #1;
    n_checks++;
    if ({wr_valid, wr_sof, wr_eol, wr_eof, cap_busy, frame_done, frame_dropped, timeout_err} !== 8'b0 ||
        frame_count !== 16'd0)
      $display("FAIL async_reset: outs=%b count=%0d expected all 0",
               {wr_valid, wr_sof, wr_eol, wr_eof, cap_busy, frame_done, frame_dropped, timeout_err}, frame_count);
    else n_pass++;
    sensor_datavalid = 1'b0;
    cyc();
    cam_reset = 1'b0;
    exp_count = 0;
    cyc();
    arm(); drive_frame(4, 2, -1, 0, 0, 0, 0); exp_count++;
    n_checks++;
    if (frame_count !== 16'(exp_count)) $display("FAIL post_reset_count: got %0d expected %0d", frame_count, exp_count);
    else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_shot();
    test_continuous();
    test_abort();
    test_window_edges();
    test_cfg_midframe();
    test_random_frames();
    test_timeout();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
